ft_tx_pattern_gen: RTL

// - Parametrised traffic source for the FT601 write FIFO (bd_sys wr_* port); next generation of the bring-up byte counter.
// - Emits bursts of one header word plus BURST_LEN payload words in one of four patterns, with an optional idle gap between bursts.
// - Supports a finite burst count or free-run, and keeps word/burst statistics for host-side throughput and integrity checks.

---
 rtl/ft_tx_pattern_gen_pkg.sv | 22 ++
 rtl/ft_tx_pattern_gen_lfsr.sv | 27 ++
 rtl/ft_tx_pattern_gen.sv | 165 ++++++++++++++++
 3 files changed

// File: rtl/ft_tx_pattern_gen_pkg.sv
// Shared types for the FT601 write-side traffic generator: pattern modes,
// FSM states and the header marker byte.
package ft_pkg;

  typedef enum logic [1:0] {
    BYTE_INC = 2'd0,
    WORD_INC = 2'd1,
    LFSR     = 2'd2,
    WALK1    = 2'd3
  } pattern_mode_t;

  typedef enum logic [2:0] {
    S_IDLE,
    S_HEADER,
    S_PAYLOAD,
    S_GAP,
    S_DONE
  } ft_state_t;

  localparam logic [7:0] HDR_MARKER = 8'hA5;

endpackage

// File: rtl/ft_tx_pattern_gen_lfsr.sv
// Galois LFSR payload source; emits the current value and steps once per
// payload write, reloading the seed at the start of each run.
module ft_pattern_lfsr #(
  parameter int                DATA_W    = 32,
  parameter logic [DATA_W-1:0] LFSR_POLY = DATA_W'(32'h8020_0003),
  parameter logic [DATA_W-1:0] LFSR_SEED = DATA_W'(32'h0000_0001)
) (
  input  logic              wr_clk,
  input  logic              nrst,
  input  logic              load,
  input  logic              step,
  output logic [DATA_W-1:0] value
);

  // NOTE: sequential state always uses non-blocking assignments so every
  // register samples pre-edge values, matching real flip-flop behaviour.
  always_ff @(posedge wr_clk or negedge nrst) begin
    if (!nrst) begin
      value <= LFSR_SEED;
    end else if (load) begin
      value <= LFSR_SEED;
    end else if (step) begin
      value <= (value >> 1) ^ (value[0] ? LFSR_POLY : '0);
    end
  end

endmodule

// File: rtl/ft_tx_pattern_gen.sv
// FT601 write-FIFO traffic source: header + BURST_LEN payload words per burst
// in one of four patterns, with optional idle gap and run statistics.
module ft_tx_pattern_gen
  import ft_pkg::*;
#(
  parameter int                DATA_W    = 32,
  parameter int                BURST_LEN = 256,
  parameter int                GAP_CYC   = 0,
  parameter logic [DATA_W-1:0] LFSR_POLY = DATA_W'(32'h8020_0003),
  parameter logic [DATA_W-1:0] LFSR_SEED = DATA_W'(32'h0000_0001)
) (
  input  logic              wr_clk,
  input  logic              nrst,
  input  logic              ft_ready,
  input  logic              start,
  input  logic              stop,
  input  logic [1:0]        mode,
  input  logic [15:0]       num_bursts,
  input  logic              wr_full,
  output logic              wr_en,
  output logic [DATA_W-1:0] wr_data,
  output logic              busy,
  output logic              done,
  output logic [31:0]       word_cnt,
  output logic [15:0]       burst_cnt
);

  localparam int BPW = DATA_W / 8;
  localparam int IW  = (BURST_LEN > 1) ? $clog2(BURST_LEN) : 1;
  localparam int GW  = (GAP_CYC > 1) ? $clog2(GAP_CYC) : 1;
  localparam int KW  = $clog2(DATA_W);

  ft_state_t         state;
  pattern_mode_t     mode_q;
  logic [15:0]       num_bursts_q;
  logic              stop_pend;
  logic [IW-1:0]     idx;
  logic [GW-1:0]     gap_cnt;
  logic [7:0]        byte_base;
  logic [DATA_W-1:0] word_val;
  logic [KW-1:0]     walk_k;
  logic [DATA_W-1:0] lfsr_val;
  logic [DATA_W-1:0] byte_word;
  logic [DATA_W-1:0] pay_word;
  logic              last_word;
  logic              last_burst;
  logic              start_ok;

  assign wr_en    = (state == S_HEADER || state == S_PAYLOAD) && ft_ready && !wr_full;
  assign busy     = !(state == S_IDLE || state == S_DONE);
  assign done     = (state == S_DONE);
  assign start_ok = start && !busy;

  assign last_word  = (idx == IW'(BURST_LEN - 1));
  // A stop arriving together with the final write still ends the run here.
  assign last_burst = ((num_bursts_q != 16'd0) &&
                       (({1'b0, burst_cnt} + 17'd1) == {1'b0, num_bursts_q})) ||
                      stop_pend || stop;

  ft_pattern_lfsr #(
    .DATA_W   (DATA_W),
    .LFSR_POLY(LFSR_POLY),
    .LFSR_SEED(LFSR_SEED)
  ) u_lfsr (
    .wr_clk(wr_clk),
    .nrst  (nrst),
    .load  (start_ok),
    .step  (wr_en && state == S_PAYLOAD),
    .value (lfsr_val)
  );

  // NOTE: every combinational output gets a default before the case so no
  // path leaves it unassigned, which would otherwise infer a latch.
  always_comb begin
    byte_word = '0;
    for (int i = 0; i < BPW; i++) begin
      byte_word[8*i +: 8] = byte_base + 8'(i);
    end
    pay_word = '0;
    case (mode_q)
      BYTE_INC: pay_word = byte_word;
      WORD_INC: pay_word = word_val;
      LFSR:     pay_word = lfsr_val;
      WALK1:    pay_word = {{(DATA_W-1){1'b0}}, 1'b1} << walk_k;
      default:  pay_word = '0;
    endcase
    wr_data = '0;
    case (state)
      S_HEADER:  wr_data = DATA_W'({HDR_MARKER, 6'b0, mode_q, burst_cnt});
      S_PAYLOAD: wr_data = pay_word;
      default:   wr_data = '0;
    endcase
  end

  always_ff @(posedge wr_clk or negedge nrst) begin
    if (!nrst) begin
      state        <= S_IDLE;
      mode_q       <= BYTE_INC;
      num_bursts_q <= '0;
      stop_pend    <= 1'b0;
      idx          <= '0;
      gap_cnt      <= '0;
      byte_base    <= '0;
      word_val     <= '0;
      walk_k       <= '0;
      word_cnt     <= '0;
      burst_cnt    <= '0;
    end else begin
      case (state)
        S_IDLE, S_DONE: begin
          if (start) begin
            state        <= S_HEADER;
            mode_q       <= pattern_mode_t'(mode);
            num_bursts_q <= num_bursts;
            stop_pend    <= stop;
            idx          <= '0;
            gap_cnt      <= '0;
            byte_base    <= '0;
            word_val     <= '0;
            walk_k       <= '0;
            word_cnt     <= '0;
            burst_cnt    <= '0;
          end
        end
        S_HEADER: begin
          if (stop) stop_pend <= 1'b1;
          if (wr_en) begin
            word_cnt <= word_cnt + 32'd1;
            idx      <= '0;
            state    <= S_PAYLOAD;
          end
        end
        S_PAYLOAD: begin
          if (stop) stop_pend <= 1'b1;
          if (wr_en) begin
            word_cnt  <= word_cnt + 32'd1;
            byte_base <= byte_base + 8'(BPW);
            word_val  <= word_val + 1'b1;
            walk_k    <= (walk_k == KW'(DATA_W - 1)) ? '0 : walk_k + 1'b1;
            if (last_word) begin
              idx     <= '0;
              gap_cnt <= '0;
              if (burst_cnt != 16'hFFFF) burst_cnt <= burst_cnt + 16'd1;
              if (last_burst)       state <= S_DONE;
              else if (GAP_CYC > 0) state <= S_GAP;
              else                  state <= S_HEADER;
            end else begin
              idx <= idx + 1'b1;
            end
          end
        end
        S_GAP: begin
          if (stop) stop_pend <= 1'b1;
          if (gap_cnt == GW'(GAP_CYC - 1)) begin
            state <= (stop_pend || stop) ? S_DONE : S_HEADER;
          end else begin
            gap_cnt <= gap_cnt + 1'b1;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule
